// File: rtl/pio_arb_pkg.sv
// Shared types and helpers for the PIO read arbiter.
// The tag carries a requester index from grant to response.
package pio_arb_pkg;

    localparam int MAX_N_REQ = 8;
    localparam int MAX_IDX_W = $clog2(MAX_N_REQ);

    // The index width never drops below one bit, so two requesters still get a usable pointer.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/pio_read_arbiter_rr.sv
// Combinational round-robin picker.
// It grants the first requester found at or after ptr, wrapping cyclically.
module rr_arbiter
    import pio_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_grant && req[j]) begin
                any_grant = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pio_read_arbiter.sv
// Shares one fixed-latency PIO read slave among N_REQ requesters.
// Grants are round-robin, one per cycle; responses are tagged back to their requester.
module pio_read_arbiter
    import pio_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [ADDR_W-1:0]        pio_address,
    input  logic [DATA_W-1:0]        pio_readdata
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int DEPTH = 1 + ADDR_REG;

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              any_grant;
    logic              take;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  rr_ptr_next;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] addr_reg;
    tag_t              tag_next;
    tag_t              tag_reg [DEPTH];

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Reset masks the grant so nothing is handed out while the fabric is held.
    assign take      = any_grant & ~reset;
    assign req_ready = reset ? '0 : grant;
    assign win_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (take) begin
            if (grant_idx == IDX_W'(N_REQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + 1'b1;
            end
        end
        tag_next.valid = take;
        tag_next.idx   = MAX_IDX_W'(grant_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= '0;
            addr_reg   <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (take) begin
                addr_reg <= win_addr;
            end
            tag_reg[0] <= tag_next;
            for (int s = 1; s < DEPTH; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    // addr_reg doubles as the idle hold value and as the timing-closure register.
    generate
        if (ADDR_REG == 0) begin : g_addr_comb
            assign pio_address = take ? win_addr : addr_reg;
        end else begin : g_addr_reg
            assign pio_address = addr_reg;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_reg[DEPTH-1].valid &&
                                   (tag_reg[DEPTH-1].idx == MAX_IDX_W'(gi));
        end
    endgenerate

    assign rsp_data = pio_readdata;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Bench for pio_read_arbiter: one DUT per ADDR_REG setting, shared stimulus,
// a transaction-level model plus directed literal checks.
module tb_pio_read_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_addr = '0;
    logic [31:0] in_port = '0;

    logic [3:0]  ready0, ready1, rsp_valid0, rsp_valid1;
    logic [31:0] rsp_data0, rsp_data1, rd0, rd1;
    logic [1:0]  pio0, pio1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    pio_read_arbiter #(.N_REQ(N), .ADDR_W(2), .DATA_W(32), .ADDR_REG(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready0), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
        .pio_address(pio0), .pio_readdata(rd0));

    pio_read_arbiter #(.N_REQ(N), .ADDR_W(2), .DATA_W(32), .ADDR_REG(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .pio_address(pio1), .pio_readdata(rd1));

    // PIO input slaves: data register at address 0, everything else reads 0.
    always @(posedge clk) rd0 <= (pio0 == 2'd0) ? in_port : 32'd0;
    always @(posedge clk) rd1 <= (pio1 == 2'd0) ? in_port : 32'd0;

    function automatic int winner(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [1:0] addr_of(input logic [7:0] a, input int i);
        return a[i*2 +: 2];
    endfunction

    function automatic logic [31:0] slave(input logic [1:0] a, input logic [31:0] port);
        return (a == 2'd0) ? port : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference: pointer, last address and in-flight responses.
    int          m_ptr;
    logic [1:0]  m_last_addr;
    logic        m0_v,  m1a_v,  m1b_v;
    int          m0_idx, m1a_idx, m1b_idx;
    logic [31:0] m0_data, m1b_data;
    logic [1:0]  m1a_addr;

    always @(posedge clk or posedge reset) begin : mdl
        int w;
        if (reset) begin
            m_ptr <= 0; m_last_addr <= '0;
            m0_v <= 1'b0; m1a_v <= 1'b0; m1b_v <= 1'b0;
            m0_idx <= 0; m1a_idx <= 0; m1b_idx <= 0;
            m0_data <= '0; m1b_data <= '0; m1a_addr <= '0;
        end else begin
            w = winner(req_valid, m_ptr);
            m1b_v    <= m1a_v;
            m1b_idx  <= m1a_idx;
            m1b_data <= slave(m1a_addr, in_port);
            m1a_v    <= (w >= 0);
            m0_v     <= (w >= 0);
            if (w >= 0) begin
                m1a_idx     <= w;
                m1a_addr    <= addr_of(req_addr, w);
                m0_idx      <= w;
                m0_data     <= slave(addr_of(req_addr, w), in_port);
                m_ptr       <= (w + 1) % N;
                m_last_addr <= addr_of(req_addr, w);
            end
        end
    end

    always @(negedge clk) begin : cmp
        int w;
        logic [3:0] er;
        if (chk_en) begin
            w  = reset ? -1 : winner(req_valid, m_ptr);
            er = (w >= 0) ? 4'(1 << w) : 4'd0;
            check("ready0", 32'(ready0), 32'(er));
            check("ready1", 32'(ready1), 32'(er));
            check("pio0", 32'(pio0), 32'((w >= 0) ? addr_of(req_addr, w) : m_last_addr));
            check("pio1", 32'(pio1), 32'(m_last_addr));
            check("rsp_valid0", 32'(rsp_valid0), m0_v ? 32'(1 << m0_idx) : 32'd0);
            check("rsp_valid1", 32'(rsp_valid1), m1b_v ? 32'(1 << m1b_idx) : 32'd0);
            if (m0_v)  check("rsp_data0", rsp_data0, m0_data);
            if (m1b_v) check("rsp_data1", rsp_data1, m1b_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] g;
        repeat (2) tick();
        reset = 1'b0;
        chk_en = 1'b1;

        settle();
        $display("[TB] reset/idle");
        check("idle_ready0", 32'(ready0), 32'd0);
        check("idle_rsp0", 32'(rsp_valid0), 32'd0);
        check("idle_rsp1", 32'(rsp_valid1), 32'd0);
        check("idle_pio0", 32'(pio0), 32'd0);
        check("idle_pio1", 32'(pio1), 32'd0);

        tick();
        req_valid = 4'b0100; req_addr = 8'h00; in_port = 32'hDEADBEEF;
        settle();
        check("single_ready", 32'(ready0), 32'h4);
        for (int k = 1; k < 4; k++) begin
            tick(); settle();
            $display("[TB] single req2 beat %0d rsp_valid=%b data=%h", k, rsp_valid0, rsp_data0);
            check("single_ready", 32'(ready0), 32'h4);
            check("single_rsp", 32'(rsp_valid0), 32'h4);
            check("single_data", rsp_data0, 32'hDEADBEEF);
        end

        tick();
        reset = 1'b1; req_valid = 4'b0000;
        settle();
        check("midreset_rsp0", 32'(rsp_valid0), 32'd0);
        check("midreset_ready", 32'(ready0), 32'd0);
        tick();
        reset = 1'b0; req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            settle();
            $display("[TB] all-valid beat %0d grant=%b rsp=%b", k, ready0, rsp_valid0);
            check("rr_grant", 32'(ready0), 32'(1 << (k % 4)));
            if (k > 0) check("rr_rsp", 32'(rsp_valid0), 32'(1 << ((k - 1) % 4)));
            tick();
        end

        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            settle();
            $display("[TB] req1+3 beat %0d grant=%b", k, ready0);
            check("pair_grant", 32'(ready0), (k == 1) ? 32'h2 : 32'h8);
            tick();
        end

        reset = 1'b1; req_valid = 4'b0000;
        settle();
        check("midreset_rsp1", 32'(rsp_valid1), 32'd0);
        tick();
        reset = 1'b0; req_valid = 4'b0011; req_addr = 8'b0000_0001; in_port = 32'h12345678;
        settle();
        check("addr_grant0", 32'(ready0), 32'h1);
        check("addr_pio0_T", 32'(pio0), 32'h1);
        tick();
        req_valid = 4'b0010;
        settle();
        check("addr_grant1", 32'(ready0), 32'h2);
        check("addr_pio0_T1", 32'(pio0), 32'h0);
        check("areg_pio1_T1", 32'(pio1), 32'h1);
        check("addr_rsp0", 32'(rsp_valid0), 32'h1);
        check("addr_data0", rsp_data0, 32'h0);
        tick();
        req_valid = 4'b0000;
        settle();
        check("addr_rsp1", 32'(rsp_valid0), 32'h2);
        check("addr_data1", rsp_data0, 32'h12345678);
        check("areg_pio1_T2", 32'(pio1), 32'h0);
        check("areg_rsp_T2", 32'(rsp_valid1), 32'h1);
        check("areg_data_T2", rsp_data1, 32'h0);
        tick();
        settle();
        $display("[TB] addr_reg rsp=%b data=%h", rsp_valid1, rsp_data1);
        check("areg_rsp_T3", 32'(rsp_valid1), 32'h2);
        check("areg_data_T3", rsp_data1, 32'h12345678);
        check("areg_rsp0_idle", 32'(rsp_valid0), 32'h0);

        // Random traffic: ungranted requesters keep their address; a request may be withdrawn.
        for (int c = 0; c < 3000; c++) begin
            settle();
            g = ready0;
            tick();
            if ($urandom_range(0, 3) == 0) in_port = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !g[i]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i*2 +: 2] = 2'($urandom_range(0, 3));
                end
            end
        end
        tick();
        reset = 1'b0; req_valid = '0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
